// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one variable-latency memory port between instruction fetch and
// data load/store. Each side has a one-deep pending slot. Only one memory
// transaction is outstanding at a time. Data has priority, but after
// STARVE_LIMIT consecutive data grants with a fetch waiting, the fetch wins.
// Each response is routed back to the side that owns the flight.
//
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_i_valid_addr/i_i_addr           fetch request pulse + address
//   i_flush                           cancel older fetch state (taken jump)
//   o_i_valid_inst/o_i_inst           fetch response pulse + 32-bit instruction
//   i_d_valid_addr/i_d_addr/i_d_wen/i_d_wdata  data request pulse + payload
//   o_d_valid/o_d_rdata               data completion pulse + load data (0 for stores)
//   o_m_valid/o_m_addr/o_m_wen/o_m_wdata       memory request (registered)
//   i_m_valid_data/i_m_rdata          memory response/ack
//   o_err                             sticky protocol-error flag
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_i_valid_addr,
    input  logic [ADDR_W-1:0] i_i_addr,
    input  logic              i_flush,
    output logic              o_i_valid_inst,
    output logic [31:0]       o_i_inst,
    input  logic              i_d_valid_addr,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic              i_d_wen,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_valid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_m_valid,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic              o_m_wen,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic              i_m_valid_data,
    input  logic [DATA_W-1:0] i_m_rdata,
    output logic              o_err
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t state, state_nx;

    logic              i_pend;
    logic [ADDR_W-1:0] i_pend_addr;
    logic              d_pend;
    logic [ADDR_W-1:0] d_pend_addr;
    logic              d_pend_wen;
    logic [DATA_W-1:0] d_pend_wdata;
    logic [3:0]        starve_cnt;
    logic              fl_hi;      // in-flight fetch selects upper word
    logic              fl_cancel;  // in-flight fetch was flushed
    logic              fl_store;   // in-flight data op is a store

    logic              idle;
    logic              i_occ, i_acc, i_drop;
    logic              d_occ, d_acc, d_drop;
    logic              ip, dp;
    logic [ADDR_W-1:0] ia, da;
    logic              dw;
    logic [DATA_W-1:0] dwd;
    logic              grant_i, grant_d;
    logic              resp, mem_err;

    always_comb begin
        idle   = (state == IDLE);
        // A flush retires all older fetch state, so a fetch in the same
        // cycle is never treated as a re-request.
        i_occ  = !i_flush && (i_pend || (state == BUSY_I && !fl_cancel));
        i_acc  = i_i_valid_addr && !i_occ;
        i_drop = i_i_valid_addr && i_occ;
        d_occ  = d_pend || (state == BUSY_D);
        d_acc  = i_d_valid_addr && !d_occ;
        d_drop = i_d_valid_addr && d_occ;

        // Effective pending requests, with same-cycle arrivals bypassed in.
        ip  = (i_pend && !i_flush) || i_acc;
        ia  = i_acc ? i_i_addr : i_pend_addr;
        dp  = d_pend || d_acc;
        da  = d_acc ? i_d_addr  : d_pend_addr;
        dw  = d_acc ? i_d_wen   : d_pend_wen;
        dwd = d_acc ? i_d_wdata : d_pend_wdata;

        grant_i = idle && ip && (!dp || starve_cnt == LIMIT);
        grant_d = idle && dp && !grant_i;
        resp    = i_m_valid_data && !idle;
        mem_err = i_m_valid_data && idle;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_i)      state_nx = BUSY_I;
                else if (grant_d) state_nx = BUSY_D;
            end
            BUSY_I, BUSY_D: if (i_m_valid_data) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            i_pend         <= 1'b0;
            i_pend_addr    <= '0;
            d_pend         <= 1'b0;
            d_pend_addr    <= '0;
            d_pend_wen     <= 1'b0;
            d_pend_wdata   <= '0;
            starve_cnt     <= '0;
            fl_hi          <= 1'b0;
            fl_cancel      <= 1'b0;
            fl_store       <= 1'b0;
            o_m_valid      <= 1'b0;
            o_m_addr       <= '0;
            o_m_wen        <= 1'b0;
            o_m_wdata      <= '0;
            o_i_valid_inst <= 1'b0;
            o_i_inst       <= '0;
            o_d_valid      <= 1'b0;
            o_d_rdata      <= '0;
            o_err          <= 1'b0;
        end else begin
            // Pending slots: a granted request never lands in its slot.
            if (grant_i)      i_pend <= 1'b0;
            else if (i_acc) begin
                i_pend      <= 1'b1;
                i_pend_addr <= i_i_addr;
            end else if (i_flush) i_pend <= 1'b0;

            if (grant_d)      d_pend <= 1'b0;
            else if (d_acc) begin
                d_pend       <= 1'b1;
                d_pend_addr  <= i_d_addr;
                d_pend_wen   <= i_d_wen;
                d_pend_wdata <= i_d_wdata;
            end

            if (grant_i)            starve_cnt <= '0;
            else if (grant_d && ip) starve_cnt <= starve_cnt + 4'd1;
            else if (!ip)           starve_cnt <= '0;

            if (grant_i)                          fl_cancel <= 1'b0;
            else if (i_flush && state == BUSY_I)  fl_cancel <= 1'b1;

            o_m_valid <= grant_i || grant_d;
            if (grant_i) begin
                o_m_addr  <= ia;
                o_m_wen   <= 1'b0;
                o_m_wdata <= '0;
                fl_hi     <= ia[2];
            end else if (grant_d) begin
                o_m_addr  <= da;
                o_m_wen   <= dw;
                o_m_wdata <= dwd;
                fl_store  <= dw;
            end

            // A flush landing with the response also suppresses it.
            o_i_valid_inst <= resp && state == BUSY_I && !fl_cancel && !i_flush;
            if (resp && state == BUSY_I && !fl_cancel && !i_flush)
                o_i_inst <= fl_hi ? i_m_rdata[63:32] : i_m_rdata[31:0];

            o_d_valid <= resp && state == BUSY_D;
            if (resp && state == BUSY_D)
                o_d_rdata <= fl_store ? '0 : i_m_rdata;

            o_err <= o_err | i_drop | d_drop | mem_err;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_iv = 1'b0, i_fl = 1'b0, i_dv = 1'b0, i_dw = 1'b0, i_mv = 1'b0;
    logic [63:0] i_ia = '0, i_da = '0, i_wd = '0, i_mr = '0;
    logic        o_iv, o_dv, o_mv, o_mw, o_err;
    logic [31:0] o_inst;
    logic [63:0] o_drd, o_ma, o_mwd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_i_valid_addr(i_iv), .i_i_addr(i_ia), .i_flush(i_fl),
        .o_i_valid_inst(o_iv), .o_i_inst(o_inst),
        .i_d_valid_addr(i_dv), .i_d_addr(i_da), .i_d_wen(i_dw), .i_d_wdata(i_wd),
        .o_d_valid(o_dv), .o_d_rdata(o_drd),
        .o_m_valid(o_mv), .o_m_addr(o_ma), .o_m_wen(o_mw), .o_m_wdata(o_mwd),
        .i_m_valid_data(i_mv), .i_m_rdata(i_mr), .o_err(o_err)
    );

    typedef struct {
        logic iv; logic [63:0] ia; logic fl;
        logic dv; logic [63:0] da; logic dw; logic [63:0] wd;
        logic mv; logic [63:0] mr;
        logic e_mv; logic [63:0] e_ma; logic e_mw; logic [63:0] e_mwd;
        logic e_iv; logic [31:0] e_inst;
        logic e_dv; logic [63:0] e_drd;
        logic e_err;
    } vec_t;

    vec_t tbl[$];

    // Row: inputs (fetch, flush, data, mem response) then expected outputs
    // after the clock edge that samples them.
    task automatic add(input logic iv, input logic [63:0] ia, input logic fl,
                       input logic dv, input logic [63:0] da, input logic dw, input logic [63:0] wd,
                       input logic mv, input logic [63:0] mr,
                       input logic e_mv, input logic [63:0] e_ma, input logic e_mw, input logic [63:0] e_mwd,
                       input logic e_iv, input logic [31:0] e_inst,
                       input logic e_dv, input logic [63:0] e_drd, input logic e_err);
        vec_t v;
        v.iv = iv; v.ia = ia; v.fl = fl; v.dv = dv; v.da = da; v.dw = dw; v.wd = wd;
        v.mv = mv; v.mr = mr; v.e_mv = e_mv; v.e_ma = e_ma; v.e_mw = e_mw; v.e_mwd = e_mwd;
        v.e_iv = e_iv; v.e_inst = e_inst; v.e_dv = e_dv; v.e_drd = e_drd; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_iv = v.iv; i_ia = v.ia; i_fl = v.fl;
        i_dv = v.dv; i_da = v.da; i_dw = v.dw; i_wd = v.wd;
        i_mv = v.mv; i_mr = v.mr;
    endtask

    task automatic idle_inputs();
        i_iv = 0; i_fl = 0; i_dv = 0; i_dw = 0; i_mv = 0;
        i_ia = '0; i_da = '0; i_wd = '0; i_mr = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".m_valid"}, 64'(o_mv), 64'd0);
        chk({tag, ".m_addr"},  o_ma, 64'd0);
        chk({tag, ".m_wen"},   64'(o_mw), 64'd0);
        chk({tag, ".m_wdata"}, o_mwd, 64'd0);
        chk({tag, ".i_valid"}, 64'(o_iv), 64'd0);
        chk({tag, ".i_inst"},  64'(o_inst), 64'd0);
        chk({tag, ".d_valid"}, 64'(o_dv), 64'd0);
        chk({tag, ".d_rdata"}, o_drd, 64'd0);
        chk({tag, ".err"},     64'(o_err), 64'd0);
    endtask

    task automatic run_row(input int r, input vec_t v);
        string s;
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        s = $sformatf("row%0d", r);
        chk({s, ".m_valid"}, 64'(o_mv), 64'(v.e_mv));
        if (v.e_mv) begin
            chk({s, ".m_addr"}, o_ma, v.e_ma);
            chk({s, ".m_wen"}, 64'(o_mw), 64'(v.e_mw));
            if (v.e_mw) chk({s, ".m_wdata"}, o_mwd, v.e_mwd);
        end
        chk({s, ".i_valid"}, 64'(o_iv), 64'(v.e_iv));
        if (v.e_iv) chk({s, ".i_inst"}, 64'(o_inst), 64'(v.e_inst));
        chk({s, ".d_valid"}, 64'(o_dv), 64'(v.e_dv));
        if (v.e_dv) chk({s, ".d_rdata"}, o_drd, v.e_drd);
        chk({s, ".err"}, 64'(o_err), 64'(v.e_err));
    endtask

    initial begin
        //  iv ia          fl dv da       dw wd                      mv mr                      | e_mv e_ma  e_mw e_mwd                    e_iv e_inst        e_dv e_drd                   e_err
        // 1: fetch only
        add(1, 64'h4,      0, 0, 0,       0, 0,                      0, 0,                        1, 64'h4,   0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        0, 0,       0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        0, 0,       0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'hDEADBEEF_00000013,    0, 0,       0, 0,                      1, 32'hDEADBEEF,  0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        0, 0,       0, 0,                      0, 0,             0, 0,                      0);
        // 2: store then load
        add(0, 0,          0, 1, 64'h10,  1, 64'h1122334455667788,   0, 0,                        1, 64'h10,  1, 64'h1122334455667788,   0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'hFFFF_FFFF_FFFF_FFFF,  0, 0,       0, 0,                      0, 0,             1, 64'h0,                  0);
        add(0, 0,          0, 1, 64'h10,  0, 0,                      0, 0,                        1, 64'h10,  0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        0, 0,       0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h1122334455667788,     0, 0,       0, 0,                      0, 0,             1, 64'h1122334455667788,   0);
        // 3: simultaneous requests, data first, no cross-talk
        add(1, 64'h20,     0, 1, 64'h30,  0, 0,                      0, 0,                        1, 64'h30,  0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'hAAAABBBBCCCCDDDD,     0, 0,       0, 0,                      0, 0,             1, 64'hAAAABBBBCCCCDDDD,   0);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        1, 64'h20,  0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h5555666677778888,     0, 0,       0, 0,                      1, 32'h77778888,  0, 0,                      0);
        // 4: starvation, grant order D,D,I,D
        add(1, 64'h100,    0, 1, 64'h200, 0, 0,                      0, 0,                        1, 64'h200, 0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h1,                    0, 0,       0, 0,                      0, 0,             1, 64'h1,                  0);
        add(0, 0,          0, 1, 64'h208, 0, 0,                      0, 0,                        1, 64'h208, 0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h2,                    0, 0,       0, 0,                      0, 0,             1, 64'h2,                  0);
        add(0, 0,          0, 1, 64'h210, 0, 0,                      0, 0,                        1, 64'h100, 0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h9999AAAA_BBBBCCCC,    0, 0,       0, 0,                      1, 32'hBBBBCCCC,  0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        1, 64'h210, 0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h3,                    0, 0,       0, 0,                      0, 0,             1, 64'h3,                  0);
        // 5: flush in flight with post-jump fetch in the same cycle
        add(1, 64'h8,      0, 0, 0,       0, 0,                      0, 0,                        1, 64'h8,   0, 0,                      0, 0,             0, 0,                      0);
        add(1, 64'h40,     1, 0, 0,       0, 0,                      0, 0,                        0, 0,       0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h12345678_9ABCDEF0,    0, 0,       0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        1, 64'h40,  0, 0,                      0, 0,             0, 0,                      0);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h000000AB_000000CD,    0, 0,       0, 0,                      1, 32'h000000CD,  0, 0,                      0);
        // 6: re-request while fetch pending sets sticky error, transaction unaffected
        add(1, 64'h50,     0, 1, 64'h58,  0, 0,                      0, 0,                        1, 64'h58,  0, 0,                      0, 0,             0, 0,                      0);
        add(1, 64'h60,     0, 0, 0,       0, 0,                      0, 0,                        0, 0,       0, 0,                      0, 0,             0, 0,                      1);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'hCAFEF00D_12345678,    0, 0,       0, 0,                      0, 0,             1, 64'hCAFEF00D_12345678,  1);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        1, 64'h50,  0, 0,                      0, 0,             0, 0,                      1);
        add(0, 0,          0, 0, 0,       0, 0,                      1, 64'h11111111_22222222,    0, 0,       0, 0,                      1, 32'h22222222,  0, 0,                      1);
        add(0, 0,          0, 0, 0,       0, 0,                      0, 0,                        0, 0,       0, 0,                      0, 0,             0, 0,                      1);
        // start a store, then reset mid-flight
        add(0, 0,          0, 1, 64'h70,  1, 64'hABCD,               0, 0,                        1, 64'h70,  1, 64'hABCD,               0, 0,             0, 0,                      1);

        // Reset state
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < tbl.size(); r++) run_row(r, tbl[r]);

        // Async reset while BUSY_D: outputs clear without a clock edge.
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");

        // Stale memory response right after release: ignored, flags error.
        @(negedge clk);
        rst = 1'b0;
        i_mv = 1'b1;
        i_mr = 64'h5A5A5A5A_5A5A5A5A;
        @(posedge clk);
        #1;
        chk("stale.d_valid", 64'(o_dv), 64'd0);
        chk("stale.i_valid", 64'(o_iv), 64'd0);
        chk("stale.m_valid", 64'(o_mv), 64'd0);
        chk("stale.err", 64'(o_err), 64'd1);

        // Arbiter still works after reset: fetch granted with 1-cycle latency.
        @(negedge clk);
        idle_inputs();
        i_iv = 1'b1;
        i_ia = 64'hC;
        @(posedge clk);
        #1;
        chk("post.m_valid", 64'(o_mv), 64'd1);
        chk("post.m_addr", o_ma, 64'hC);
        @(negedge clk);
        idle_inputs();
        i_mv = 1'b1;
        i_mr = 64'h87654321_0BADC0DE;
        @(posedge clk);
        #1;
        chk("post.i_valid", 64'(o_iv), 64'd1);
        chk("post.i_inst", 64'(o_inst), 64'h87654321);
        @(negedge clk);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one variable-latency memory port between the instruction-fetch requester and the data (load/store) requester.
- Captures single-cycle request pulses, arbitrates with bounded data priority, and keeps one transaction outstanding at a time.
- Routes each response back to its owner.
- Sits between the fetch/EX stages and the unified memory model, and honours fetch flushes on taken jumps.

Parameters:
ADDR_W, 64, address width of both requesters and the memory port
DATA_W, 64, memory data width; must be 64
STARVE_LIMIT, 2, maximum consecutive data grants while an instruction request waits; range 1..15

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_i_valid_addr  in  1  fetch request pulse
i_i_addr  in  ADDR_W  fetch address, 4-byte aligned
i_flush  in  1  cancel the pending or in-flight fetch (EX0 taken jump)
o_i_valid_inst  out  1  fetch response pulse
o_i_inst  out  32  fetched instruction
i_d_valid_addr  in  1  data request pulse
i_d_addr  in  ADDR_W  data address, 8-byte aligned
i_d_wen  in  1  1=store, 0=load
i_d_wdata  in  DATA_W  store data
o_d_valid  out  1  data completion pulse, for loads and stores
o_d_rdata  out  DATA_W  load data; 0 on store completion
o_m_valid  out  1  memory request pulse
o_m_addr  out  ADDR_W  memory address
o_m_wen  out  1  memory write enable
o_m_wdata  out  DATA_W  memory write data
i_m_valid_data  in  1  memory response/ack pulse
i_m_rdata  in  DATA_W  memory read data
o_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, while i_rst=1): all outputs 0; both pending slots empty; FSM=IDLE; starve counter=0; o_err=0. Reset mid-transaction discards everything; a late i_m_valid_data after reset is ignored (FSM IDLE).
- Request capture: a request pulse at edge T loads that side's one-deep pending slot (address, wen, wdata).
- Re-request while occupied: a pulse on a side whose slot is occupied or in flight is dropped and sets o_err.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: if a slot is pending, or a request arrives this cycle (combinational bypass into the grant decision), grant it and register o_m_*; the pulse is visible one cycle after the request edge, i.e. minimum request-to-o_m_valid latency = 1 cycle. Move to BUSY_I or BUSY_D and free the granted slot.
- Arbitration when both are pending: data wins unless starve counter == STARVE_LIMIT, in which case instruction wins.
  - Counter increments on a data grant while an instruction is pending.
  - Counter clears on any instruction grant or when no instruction is pending.
- BUSY_x: o_m_valid is low. On i_m_valid_data, register the response for one cycle.
  - BUSY_I: o_i_valid_inst=1; o_i_inst = addr[2] ? rdata[63:32] : rdata[31:0].
  - BUSY_D: o_d_valid=1; o_d_rdata = rdata for a load, 0 for a store.
  - Return to IDLE in that same edge. A pending slot may be granted in the very next cycle, so back-to-back memory requests are 1 idle cycle apart minimum.
- i_flush:
  - Clears a pending instruction slot.
  - If in BUSY_I, marks the flight as cancelled; its response is consumed without asserting o_i_valid_inst.
  - A fetch request in the same cycle as i_flush is kept (the post-jump fetch); flush applies only to older state.
- Simultaneous request pulses from both sides in IDLE with empty slots: data granted, instruction captured.
- i_m_valid_data in IDLE: ignored, sets o_err.
- o_err is sticky until reset.
- Data response outputs hold their last value when the valid pulse is low; only the pulses return to 0.

Test Plan:
1. Fetch only: i_i_addr=0x4 pulse at cycle 1; memory responds 3 cycles after o_m_valid with rdata=0xDEADBEEF_00000013 -> o_m_valid at cycle 2 with addr 0x4, wen=0; o_i_valid_inst one cycle after the response; o_i_inst=0xDEADBEEF.
2. Store then load: store 0x10 with wdata 0x1122334455667788, then load 0x10 after completion -> the store yields o_d_valid with o_d_rdata=0; the load returns 0x1122334455667788.
3. Simultaneous i_i_valid_addr and i_d_valid_addr pulse -> data granted first, instruction next; responses are routed to the correct sides with no cross-talk.
4. Starvation: instruction pending while data requests arrive continuously, STARVE_LIMIT=2 -> grant order D,D,I,D...
5. Flush: fetch 0x8 in flight, i_flush asserted, new fetch 0x40 in the same cycle -> the 0x8 response is suppressed; only the 0x40 instruction is delivered.
6. Errors and reset: second fetch pulse while one is pending -> o_err=1 and the transaction is unaffected. Assert i_rst mid-BUSY_D, then deliver a stale i_m_valid_data after reset release -> all outputs 0 during reset; the stale response is ignored and o_err is set by the response arriving in IDLE.
